// File: rtl/memsplit_arb2.sv
// memsplit_arb2: two-master / one-slave round-robin arbiter for the split req/ack/resp debug bus.
// Latency: request path and read-response path are combinational (zero cycles); one read outstanding.
// Backpressure: slave withholds s_ack; the selected master stays locked until accept or it drops req.
// Ports: clk_gen/srst (sync, active-high); m{0,1}_req/we/addr/be/wdata in, m{0,1}_ack/resp/rdata out;
//        s_req/we/addr/be/wdata out, s_ack/s_resp/s_rdata in.
// Optional read-response timeout: define MEMSPLIT_ARB_TIMEOUT_EN (uses TIMEOUT_CYCLES, TIMEOUT_RDATA).
module memsplit_arb2 #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
  input  logic        clk_gen,
  input  logic        srst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_resp,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_resp,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [3:0]  s_be,
  output logic [31:0] s_wdata,
  input  logic        s_ack,
  input  logic        s_resp,
  input  logic [31:0] s_rdata
);

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_WAIT_RESP = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_last_grant;
  logic r_hold;
  logic r_held_sel;
  logic r_owner;

  logic w_hold_vld;
  logic w_sel;
  logic w_accept;
  logic w_tmo_hit;

  // Master selection, only meaningful in IDLE. A held grant is honoured only
  // while that master still requests; otherwise normal round-robin applies.
  always_comb begin
    w_hold_vld = r_hold & (r_held_sel ? m1_req : m0_req);
    w_sel      = 1'b0;
    if (r_state == S_IDLE) begin
      if (w_hold_vld)
        w_sel = r_held_sel;
      else if (m0_req & m1_req)
        w_sel = ~r_last_grant;
      else if (m1_req)
        w_sel = 1'b1;
    end
  end

  assign w_accept = s_req & s_ack;

`ifdef MEMSPLIT_ARB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] r_tmo_cnt;

  // Held at zero in IDLE, so it starts from zero on every WAIT_RESP entry.
  always_ff @(posedge clk_gen) begin
    if (srst || (r_state == S_IDLE))
      r_tmo_cnt <= '0;
    else if (!s_resp)
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign w_tmo_hit = (r_state == S_WAIT_RESP) & ~s_resp &
                     (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (^TIMEOUT_RDATA) ^ (TIMEOUT_CYCLES == 0);
  assign w_tmo_hit    = 1'b0;
`endif

  // State register and bookkeeping registers.
  always_ff @(posedge clk_gen) begin
    if (srst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_hold       <= 1'b0;
      r_held_sel   <= 1'b0;
      r_owner      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Lock the grant while the slave stalls; release on accept or withdrawal.
      r_hold  <= s_req & ~s_ack;
      if (s_req)
        r_held_sel <= w_sel;
      if (w_accept)
        r_last_grant <= w_sel;
      if (w_accept & ~s_we)
        r_owner <= w_sel;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_accept & ~s_we) w_state_nxt = S_WAIT_RESP;
      S_WAIT_RESP: if (s_resp | w_tmo_hit) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs. Everything master/slave-facing is forced quiet while srst is high,
  // so a response arriving during reset never reaches a master.
  always_comb begin
    s_req    = 1'b0;
    s_we     = w_sel ? m1_we    : m0_we;
    s_addr   = w_sel ? m1_addr  : m0_addr;
    s_be     = w_sel ? m1_be    : m0_be;
    s_wdata  = w_sel ? m1_wdata : m0_wdata;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    m0_resp  = 1'b0;
    m1_resp  = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    if (!srst) begin
      if (r_state == S_IDLE) begin
        s_req  = w_sel ? m1_req : m0_req;
        m0_ack = s_req & s_ack & ~w_sel;
        m1_ack = s_req & s_ack &  w_sel;
      end else if (s_resp | w_tmo_hit) begin
        if (r_owner) begin
          m1_resp  = 1'b1;
          m1_rdata = s_resp ? s_rdata : TIMEOUT_RDATA;
        end else begin
          m0_resp  = 1'b1;
          m0_rdata = s_resp ? s_rdata : TIMEOUT_RDATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_memsplit_arb2.sv
module tb_memsplit_arb2;

  localparam int TMO = 8;

  logic        clk_gen;
  logic        srst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_ack, m0_resp, m1_ack, m1_resp;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        s_ack, s_resp;
  logic [31:0] s_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  memsplit_arb2 #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_RDATA(32'hDEADBEEF)) dut (
    .clk_gen(clk_gen), .srst(srst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_resp(m0_resp), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_resp(m1_resp), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_be(s_be), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata)
  );

  initial clk_gen = 1'b0;
  always #5 clk_gen = ~clk_gen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clk_gen);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clr();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_be = 4'hF; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_be = 4'hF; m1_wdata = 0;
    s_ack = 0; s_resp = 0; s_rdata = 0;
  endtask

  task automatic do_reset();
    clr();
    srst = 1;
    tick();
    tick();
    srst = 0;
  endtask

  // Reference model: transaction-level view of the arbiter.
  logic        rq[2];
  logic        wr[2];
  logic [31:0] ad[2];
  logic [31:0] wd[2];
  bit          md_busy;
  int          md_owner, md_last, md_lock, md_wait, e_sel;
  bit          tmo_en;
  bit          e_sreq, e_to;
  logic        e_ack[2];
  logic        e_resp[2];
  logic [31:0] e_rd[2];

  initial begin
`ifdef MEMSPLIT_ARB_TIMEOUT_EN
    tmo_en = 1;
`else
    tmo_en = 0;
`endif
    srst = 1;
    clr();
    tick();

    // Reset state: requests and a stray response during srst produce nothing.
    m0_req = 1; m1_req = 1; s_ack = 1; s_resp = 1; s_rdata = 32'h77777777;
    settle();
    chk("rst_s_req", s_req, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);
    chk("rst_m0_resp", m0_resp, 0);
    chk("rst_m1_resp", m1_resp, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    do_reset();

    // 1. Write accepted with zero latency; back-to-back write next cycle.
    m0_req = 1; m0_we = 1; m0_addr = 32'h0; m0_wdata = 32'h00A5; s_ack = 1;
    settle();
    chk("t1_s_req", s_req, 1);
    chk("t1_s_we", s_we, 1);
    chk("t1_s_wdata", s_wdata, 32'h00A5);
    chk("t1_m0_ack", m0_ack, 1);
    chk("t1_m1_ack", m1_ack, 0);
    tick();
    m0_addr = 32'h4; m0_wdata = 32'h1234;
    settle();
    chk("t1_b2b_s_req", s_req, 1);
    chk("t1_b2b_m0_ack", m0_ack, 1);
    chk("t1_b2b_s_addr", s_addr, 32'h4);
    tick();
    clr();

    // 2. Simultaneous reads after fresh reset: m0 first, then m1.
    do_reset();
    m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h200; s_ack = 1;
    settle();
    chk("t2_s_addr_m0", s_addr, 32'h100);
    chk("t2_m0_ack", m0_ack, 1);
    chk("t2_m1_ack", m1_ack, 0);
    tick();
    m0_req = 0; s_resp = 1; s_rdata = 32'h12345678;
    settle();
    chk("t2_wait_s_req", s_req, 0);
    chk("t2_wait_m1_ack", m1_ack, 0);
    chk("t2_m0_resp", m0_resp, 1);
    chk("t2_m0_rdata", m0_rdata, 32'h12345678);
    chk("t2_m1_resp_idle", m1_resp, 0);
    tick();
    s_resp = 0;
    settle();
    chk("t2_s_addr_m1", s_addr, 32'h200);
    chk("t2_m1_ack", m1_ack, 1);
    chk("t2_m0_ack_0", m0_ack, 0);
    tick();
    m1_req = 0; s_resp = 1; s_rdata = 32'h55AA55AA;
    settle();
    chk("t2_m1_resp", m1_resp, 1);
    chk("t2_m1_rdata", m1_rdata, 32'h55AA55AA);
    chk("t2_m0_resp_0", m0_resp, 0);
    chk("t2_m0_rdata_0", m0_rdata, 0);
    tick();
    clr();

    // 3. Stalled m0 read keeps its grant although m1 would win round-robin.
    m0_req = 1; m0_we = 1; m0_addr = 32'h8; s_ack = 1;
    tick();
    m0_we = 0; m0_addr = 32'h300; s_ack = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t3_stall_addr", s_addr, 32'h300);
      chk("t3_stall_m0_ack", m0_ack, 0);
      tick();
    end
    m1_req = 1; m1_addr = 32'h400;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("t3_hold_addr", s_addr, 32'h300);
      chk("t3_hold_m1_ack", m1_ack, 0);
      tick();
    end
    s_ack = 1;
    settle();
    chk("t3_acc_addr", s_addr, 32'h300);
    chk("t3_acc_m0_ack", m0_ack, 1);
    chk("t3_acc_m1_ack", m1_ack, 0);
    tick();
    m0_req = 0; s_ack = 0; s_resp = 1; s_rdata = 32'h33;
    settle();
    chk("t3_m0_resp", m0_resp, 1);
    tick();
    s_resp = 0;

    // 4. m1 read with 5-cycle response latency; m0 waits meanwhile.
    s_ack = 1;
    settle();
    chk("t4_s_addr", s_addr, 32'h400);
    chk("t4_m1_ack", m1_ack, 1);
    tick();
    m1_req = 0; m0_req = 1; m0_we = 0; m0_addr = 32'h500;
    for (int i = 1; i < 5; i++) begin
      settle();
      chk("t4_wait_s_req", s_req, 0);
      chk("t4_wait_m0_ack", m0_ack, 0);
      chk("t4_wait_m1_resp", m1_resp, 0);
      tick();
    end
    s_resp = 1; s_rdata = 32'hCAFEF00D;
    settle();
    chk("t4_m1_resp", m1_resp, 1);
    chk("t4_m1_rdata", m1_rdata, 32'hCAFEF00D);
    chk("t4_m0_resp", m0_resp, 0);
    chk("t4_s_req_in_wait", s_req, 0);
    tick();
    s_resp = 0; s_ack = 0;
    settle();
    chk("t4_m1_resp_pulse", m1_resp, 0);
    chk("t4_m0_issued", s_req, 1);
    chk("t4_m0_addr", s_addr, 32'h500);
    tick();

    // 5. srst during WAIT_RESP discards the read.
    s_ack = 1;
    settle();
    chk("t5_m0_ack", m0_ack, 1);
    tick();
    m0_req = 0; s_ack = 0; srst = 1; s_resp = 1; s_rdata = 32'h11112222;
    settle();
    chk("t5_rst_m0_resp", m0_resp, 0);
    chk("t5_rst_m1_resp", m1_resp, 0);
    chk("t5_rst_m0_rdata", m0_rdata, 0);
    chk("t5_rst_s_req", s_req, 0);
    tick();
    srst = 0;
    settle();
    chk("t5_late_m0_resp", m0_resp, 0);
    chk("t5_late_m0_rdata", m0_rdata, 0);
    tick();
    clr();

    // 6. Unanswered read: timeout response, or indefinite wait without it.
    m0_req = 1; m0_addr = 32'h600; s_ack = 1;
    settle();
    chk("t6_m0_ack", m0_ack, 1);
    tick();
    m0_req = 0; s_ack = 0;
    for (int i = 1; i < TMO; i++) begin
      settle();
      chk("t6_no_resp_early", m0_resp, 0);
      tick();
    end
`ifdef MEMSPLIT_ARB_TIMEOUT_EN
    settle();
    chk("t6_tmo_resp", m0_resp, 1);
    chk("t6_tmo_rdata", m0_rdata, 32'hDEADBEEF);
    tick();
    s_resp = 1; s_rdata = 32'h0BADF00D;
    settle();
    chk("t6_late_m0_resp", m0_resp, 0);
    chk("t6_late_m1_resp", m1_resp, 0);
    tick();
`else
    for (int i = TMO; i <= 100; i++) begin
      settle();
      chk("t6_no_tmo_resp", m0_resp, 0);
      tick();
    end
    s_resp = 1; s_rdata = 32'h0BADF00D;
    settle();
    chk("t6_final_resp", m0_resp, 1);
    chk("t6_final_rdata", m0_rdata, 32'h0BADF00D);
    tick();
`endif
    clr();

    // Randomized traffic against the reference model.
    do_reset();
    md_busy = 0; md_owner = 0; md_last = 1; md_lock = -1; md_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      m0_req = ($urandom_range(3) != 0); m0_we = 1'($urandom_range(1));
      m0_addr = $urandom; m0_wdata = $urandom; m0_be = 4'($urandom);
      m1_req = ($urandom_range(3) != 0); m1_we = 1'($urandom_range(1));
      m1_addr = $urandom; m1_wdata = $urandom; m1_be = 4'($urandom);
      s_ack = 1'($urandom_range(1)); s_resp = ($urandom_range(3) == 0); s_rdata = $urandom;
      rq[0] = m0_req; rq[1] = m1_req; wr[0] = m0_we; wr[1] = m1_we;
      ad[0] = m0_addr; ad[1] = m1_addr; wd[0] = m0_wdata; wd[1] = m1_wdata;

      e_sreq = 0; e_sel = 0; e_to = 0;
      e_ack[0] = 0; e_ack[1] = 0; e_resp[0] = 0; e_resp[1] = 0; e_rd[0] = 0; e_rd[1] = 0;
      if (!md_busy) begin
        if (md_lock >= 0 && rq[md_lock]) e_sel = md_lock;
        else if (rq[0] && rq[1]) e_sel = 1 - md_last;
        else if (rq[1]) e_sel = 1;
        else e_sel = 0;
        e_sreq = rq[e_sel];
        e_ack[e_sel] = e_sreq && s_ack;
      end else begin
        e_to = tmo_en && (md_wait == TMO - 1);
        if (s_resp || e_to) begin
          e_resp[md_owner] = 1;
          e_rd[md_owner] = s_resp ? s_rdata : 32'hDEADBEEF;
        end
      end

      settle();
      chk("rnd_s_req", s_req, e_sreq);
      if (e_sreq) begin
        chk("rnd_s_addr", s_addr, ad[e_sel]);
        chk("rnd_s_wdata", s_wdata, wd[e_sel]);
      end
      chk("rnd_m0_ack", m0_ack, e_ack[0]);
      chk("rnd_m1_ack", m1_ack, e_ack[1]);
      chk("rnd_m0_resp", m0_resp, e_resp[0]);
      chk("rnd_m1_resp", m1_resp, e_resp[1]);
      chk("rnd_m0_rdata", m0_rdata, e_rd[0]);
      chk("rnd_m1_rdata", m1_rdata, e_rd[1]);

      if (!md_busy) begin
        if (e_sreq && s_ack) begin
          md_last = e_sel;
          md_lock = -1;
          if (!wr[e_sel]) begin
            md_busy = 1; md_owner = e_sel; md_wait = 0;
          end
        end else if (e_sreq) begin
          md_lock = e_sel;
        end else begin
          md_lock = -1;
        end
      end else if (e_resp[0] || e_resp[1]) begin
        md_busy = 0;
      end else begin
        md_wait++;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
